// File: rtl/dual_diagonal_backsub_sched.sv
// dual_diagonal_backsub_sched
//   Frame scheduler sharing one dual_diagonal_backsub datapath between two
//   encoder lanes. Arbitrates round-robin at frame boundaries, issues a
//   one-cycle datapath clear before every frame, streams NUM_WORDS words in,
//   collects NUM_WORDS results and returns them tagged with the owning lane.
//
// Ports
//   i_clock, i_reset            clock; asynchronous active-low reset
//   i_reqN_data/valid/last      lane N input word stream (N = 0, 1)
//   o_reqN_ready                lane N word accepted when valid & ready
//   o_bs_clear                  one-cycle clear to the datapath
//   o_bs_data, o_bs_valid       words to the datapath (1-cycle latency)
//   i_bs_data, i_bs_valid       datapath results (no backpressure)
//   o_out_data/valid/last/src   result stream, tagged with owning lane
//   o_busy                      scheduler not idle
//   o_err_len, o_err_timeout    one-cycle error pulses
//   o_frame_count               completed frames, wraps at 2^16
module dual_diagonal_backsub_sched #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_req0_data,
  input  logic             i_req0_valid,
  input  logic             i_req0_last,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req1_data,
  input  logic             i_req1_valid,
  input  logic             i_req1_last,
  output logic             o_req1_ready,
  output logic             o_bs_clear,
  output logic [WIDTH-1:0] o_bs_data,
  output logic             o_bs_valid,
  input  logic [WIDTH-1:0] i_bs_data,
  input  logic             i_bs_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  output logic             o_out_src,
  output logic             o_busy,
  output logic             o_err_len,
  output logic             o_err_timeout,
  output logic [15:0]      o_frame_count
);

  localparam int unsigned CW = $clog2(NUM_WORDS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] LAST_TO  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic          grant;
  logic          last_grant;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [TW-1:0] to_cnt;

  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             accept;
  logic             in_final;
  logic             in_short;
  logic             drain_beat;
  logic             res_final;
  logic             timeout_hit;
  logic             any_req;
  logic             arb_pick;

  // Ready depends on registered state only, so accept = LOAD & granted valid.
  assign o_req0_ready = (state == S_LOAD) && !grant;
  assign o_req1_ready = (state == S_LOAD) && grant;
  assign o_bs_clear   = (state == S_CLEAR);
  assign o_busy       = (state != S_IDLE);

  always_comb begin
    g_valid     = grant ? i_req1_valid : i_req0_valid;
    g_last      = grant ? i_req1_last  : i_req0_last;
    g_data      = grant ? i_req1_data  : i_req0_data;
    accept      = (state == S_LOAD) && g_valid;
    in_final    = accept && (in_cnt == LAST_IDX);
    in_short    = accept && g_last && !in_final;
    drain_beat  = (state == S_DRAIN) && i_bs_valid;
    res_final   = drain_beat && (out_cnt == LAST_IDX);
    // Completion on the final timeout cycle takes priority over the abort.
    timeout_hit = (state == S_DRAIN) && !res_final && (to_cnt == LAST_TO);
    any_req     = i_req0_valid || i_req1_valid;
    // Lone requester wins outright; a tie goes to the lane not served last.
    arb_pick    = (i_req0_valid && i_req1_valid) ? !last_grant : i_req1_valid;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_LOAD;
      S_LOAD: begin
        if (in_final)      state_nxt = S_DRAIN;
        else if (in_short) state_nxt = S_IDLE;
      end
      S_DRAIN: if (res_final || timeout_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      in_cnt        <= '0;
      out_cnt       <= '0;
      to_cnt        <= '0;
      o_bs_data     <= '0;
      o_bs_valid    <= 1'b0;
      o_out_data    <= '0;
      o_out_valid   <= 1'b0;
      o_out_last    <= 1'b0;
      o_out_src     <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_bs_valid    <= accept;
      o_out_valid   <= drain_beat;
      o_out_last    <= res_final;
      o_err_len     <= in_short || (in_final && !g_last);
      o_err_timeout <= timeout_hit;

      if (state == S_IDLE && any_req) begin
        grant      <= arb_pick;
        last_grant <= arb_pick;
      end

      if (state == S_CLEAR) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        to_cnt  <= '0;
      end

      if (accept) begin
        o_bs_data <= g_data;
        in_cnt    <= in_cnt + CW'(1);
      end

      if (state == S_DRAIN) to_cnt <= to_cnt + TW'(1);

      if (drain_beat) begin
        o_out_data <= i_bs_data;
        o_out_src  <= grant;
        out_cnt    <= out_cnt + CW'(1);
      end

      if (res_final) o_frame_count <= o_frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dual_diagonal_backsub_sched.sv
// Testbench for dual_diagonal_backsub_sched: per-lane requester drivers fed
// from word queues, a datapath model that returns a frame's words after the
// frame is fully loaded, an output monitor, and a frame-level reference model
// that splits each lane's word stream into frames and applies round-robin.
module tb_dual_diagonal_backsub_sched;
  localparam int W = 16;
  localparam int N = 8;
  localparam int T = 64;

  typedef struct packed {logic last; logic [W-1:0] d;} beat_t;
  typedef struct packed {logic src; logic last; logic [W-1:0] d;} out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [W-1:0] bs_in_data = '0;
  logic bs_in_valid = 1'b0;

  logic req0_ready, req1_ready, bs_clear, bs_valid, out_valid, out_last, out_src;
  logic busy, err_len, err_timeout;
  logic [W-1:0] bs_data, out_data;
  logic [15:0] frame_count;
  logic [2*W+25:0] all_out;

  dual_diagonal_backsub_sched #(.WIDTH(W), .NUM_WORDS(N), .TIMEOUT(T)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_req0_data(req0_data), .i_req0_valid(req0_valid), .i_req0_last(req0_last), .o_req0_ready(req0_ready),
    .i_req1_data(req1_data), .i_req1_valid(req1_valid), .i_req1_last(req1_last), .o_req1_ready(req1_ready),
    .o_bs_clear(bs_clear), .o_bs_data(bs_data), .o_bs_valid(bs_valid),
    .i_bs_data(bs_in_data), .i_bs_valid(bs_in_valid),
    .o_out_data(out_data), .o_out_valid(out_valid), .o_out_last(out_last), .o_out_src(out_src),
    .o_busy(busy), .o_err_len(err_len), .o_err_timeout(err_timeout), .o_frame_count(frame_count)
  );

  assign all_out = {req0_ready, req1_ready, bs_clear, bs_data, bs_valid, out_data, out_valid,
                    out_last, out_src, busy, err_len, err_timeout, frame_count};

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- requester drivers ----------------
  beat_t q0[$], q1[$];
  beat_t s0[$], s1[$];
  bit flush = 1'b0;
  bit pend0 = 1'b0, pend1 = 1'b0;

  always @(negedge clk) begin
    if (flush) begin q0.delete(); pend0 = 1'b0; end
    else if (pend0) begin void'(q0.pop_front()); pend0 = 1'b0; end
    if (q0.size() > 0) begin req0_valid = 1'b1; req0_data = q0[0].d; req0_last = q0[0].last; end
    else begin req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0; end
    pend0 = req0_valid && req0_ready && rst_n;
  end

  always @(negedge clk) begin
    if (flush) begin q1.delete(); pend1 = 1'b0; end
    else if (pend1) begin void'(q1.pop_front()); pend1 = 1'b0; end
    if (q1.size() > 0) begin req1_valid = 1'b1; req1_data = q1[0].d; req1_last = q1[0].last; end
    else begin req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0; end
    pend1 = req1_valid && req1_ready && rst_n;
  end

  // ---------------- datapath model ----------------
  logic [W-1:0] dp_buf[$];
  bit dp_started = 1'b0;
  int dp_wait = 0, dp_idx = 0;
  int echo_limit = N;
  bit inject_en = 1'b0;
  logic ev;
  logic [W-1:0] ed;

  always @(negedge clk) begin
    ev = 1'b0; ed = '0;
    if (!rst_n || bs_clear) begin
      dp_buf.delete(); dp_started = 1'b0; dp_idx = 0; dp_wait = 0;
    end else begin
      if (bs_valid) dp_buf.push_back(bs_data);
      if (dp_started) begin
        if (dp_wait > 0) dp_wait--;
        else if (dp_idx < N && dp_idx < echo_limit) begin ev = 1'b1; ed = dp_buf[dp_idx]; dp_idx++; end
      end else if (dp_buf.size() == N) begin
        dp_started = 1'b1; dp_wait = 2;
      end
    end
    if (inject_en && !ev && (!busy || req0_ready || req1_ready)) begin ev = 1'b1; ed = 16'hDEAD; end
    bs_in_valid = ev; bs_in_data = ed;
  end

  // ---------------- monitor ----------------
  out_t mon_out[$];
  logic [W-1:0] mon_bs[$];
  bit mon_grants[$];
  int clear_cnt = 0, errlen_cnt = 0, errto_cnt = 0, both_ready = 0;
  int bs_since_clear = 0, drain_cyc = 0, to_cyc = 0;
  bit ready_seen = 1'b0;

  always @(negedge clk) begin
    if (bs_clear) begin clear_cnt++; bs_since_clear = 0; ready_seen = 1'b0; end
    if (bs_valid) begin
      mon_bs.push_back(bs_data); bs_since_clear++;
      if (bs_since_clear == N) drain_cyc = cyc;
    end
    if (req0_ready && req1_ready) both_ready++;
    if (!ready_seen && (req0_ready || req1_ready)) begin ready_seen = 1'b1; mon_grants.push_back(req1_ready); end
    if (out_valid) mon_out.push_back({out_src, out_last, out_data});
    if (err_len) errlen_cnt++;
    if (err_timeout) begin errto_cnt++; to_cyc = cyc; end
  end

  // ---------------- reference model ----------------
  out_t exp_out[$];
  bit exp_grants[$];
  int exp_errlen, exp_frames;
  bit m_lg = 1'b1;
  logic [15:0] m_fc = '0;

  task automatic model_run();
    int p0, p1, len;
    bit v0, v1, g;
    beat_t b;
    out_t o;
    out_t fr[$];
    p0 = 0; p1 = 0;
    exp_out.delete(); exp_grants.delete(); exp_errlen = 0; exp_frames = 0;
    while (p0 < s0.size() || p1 < s1.size()) begin
      v0 = p0 < s0.size(); v1 = p1 < s1.size();
      g = (v0 && v1) ? !m_lg : !v0;
      m_lg = g; exp_grants.push_back(g);
      fr.delete(); len = 0;
      do begin
        if (g) begin b = s1[p1]; p1++; end else begin b = s0[p0]; p0++; end
        len++;
        fr.push_back({g, 1'b0, b.d});
      end while (!b.last && len < N && (g ? p1 < s1.size() : p0 < s0.size()));
      if (len < N) exp_errlen++;
      else begin
        if (!b.last) exp_errlen++;
        o = fr[len-1]; o.last = 1'b1; fr[len-1] = o;
        foreach (fr[i]) exp_out.push_back(fr[i]);
        exp_frames++;
      end
    end
  endtask

  task automatic push_frame(input bit lane, input int len, input bit with_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = W'($urandom); b.last = with_last && (i == len - 1);
      if (lane) begin q1.push_back(b); s1.push_back(b); end
      else begin q0.push_back(b); s0.push_back(b); end
    end
  endtask

  task automatic start_test();
    @(posedge clk); #2;
    s0.delete(); s1.delete();
    mon_out.delete(); mon_bs.delete(); mon_grants.delete();
    clear_cnt = 0; errlen_cnt = 0; errto_cnt = 0; both_ready = 0;
  endtask

  task automatic wait_quiet(input string name);
    int quiet = 0, n = 0;
    while (quiet < 8 && n < 3000) begin
      @(negedge clk); n++;
      if (q0.size() == 0 && q1.size() == 0 && !busy) quiet++; else quiet = 0;
    end
    total++;
    if (quiet < 8) begin bad++; $display("FAIL %s_wait: idle cycles=%0d required 8", name, quiet); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    rst_n = 1'b1; m_lg = 1'b1; m_fc = '0;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_idle: got %h expected 0", all_out); end
  endtask

  task automatic test_single_frame();
    beat_t b;
    start_test();
    for (int i = 0; i < N; i++) begin
      b.d = W'(i); b.last = (i == N - 1);
      q0.push_back(b); s0.push_back(b);
    end
    model_run(); m_fc += 16'(exp_frames);
    wait_quiet("single");
    total++;
    if (clear_cnt != 1) begin bad++; $display("FAIL single_clear: got %0d expected 1", clear_cnt); end
    total++;
    if (mon_bs.size() != N) begin bad++; $display("FAIL single_bs_count: got %0d expected %0d", mon_bs.size(), N); end
    for (int i = 0; i < N && i < mon_bs.size(); i++) begin
      total++;
      if (mon_bs[i] !== W'(i)) begin bad++; $display("FAIL single_bs[%0d]: got %h expected %h", i, mon_bs[i], W'(i)); end
    end
    total++;
    if (mon_out.size() != exp_out.size()) begin bad++; $display("FAIL single_out_count: got %0d expected %0d", mon_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < mon_out.size(); i++) begin
      total++;
      if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL single_out[%0d]: got %h expected %h", i, mon_out[i], exp_out[i]); end
    end
    total++;
    if (frame_count !== m_fc) begin bad++; $display("FAIL single_frames: got %0d expected %0d", frame_count, m_fc); end
    total++;
    if (errlen_cnt != 0 || errto_cnt != 0) begin bad++; $display("FAIL single_err: got len=%0d to=%0d expected 0 0", errlen_cnt, errto_cnt); end
  endtask

  task automatic test_round_robin();
    start_test();
    push_frame(1'b0, N, 1'b1); push_frame(1'b0, N, 1'b1);
    push_frame(1'b1, N, 1'b1); push_frame(1'b1, N, 1'b1);
    model_run(); m_fc += 16'(exp_frames);
    wait_quiet("rr");
    total++;
    if (mon_grants.size() != exp_grants.size()) begin bad++; $display("FAIL rr_grant_count: got %0d expected %0d", mon_grants.size(), exp_grants.size()); end
    for (int i = 0; i < exp_grants.size() && i < mon_grants.size(); i++) begin
      total++;
      if (mon_grants[i] !== exp_grants[i]) begin bad++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, mon_grants[i], exp_grants[i]); end
    end
    total++;
    if (both_ready != 0) begin bad++; $display("FAIL rr_ready_exclusive: got %0d overlap cycles expected 0", both_ready); end
    total++;
    if (mon_out.size() != exp_out.size()) begin bad++; $display("FAIL rr_out_count: got %0d expected %0d", mon_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < mon_out.size(); i++) begin
      total++;
      if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL rr_out[%0d]: got %h expected %h", i, mon_out[i], exp_out[i]); end
    end
    total++;
    if (frame_count !== m_fc) begin bad++; $display("FAIL rr_frames: got %0d expected %0d", frame_count, m_fc); end
  endtask

  task automatic test_len_error();
    start_test();
    push_frame(1'b1, 4, 1'b1);
    push_frame(1'b1, N, 1'b1);
    model_run(); m_fc += 16'(exp_frames);
    wait_quiet("len_short");
    total++;
    if (errlen_cnt != exp_errlen) begin bad++; $display("FAIL len_short_err: got %0d expected %0d", errlen_cnt, exp_errlen); end
    total++;
    if (mon_bs.size() != 4 + N) begin bad++; $display("FAIL len_short_bs: got %0d expected %0d", mon_bs.size(), 4 + N); end
    total++;
    if (mon_out.size() != exp_out.size()) begin bad++; $display("FAIL len_short_out_count: got %0d expected %0d", mon_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < mon_out.size(); i++) begin
      total++;
      if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL len_short_out[%0d]: got %h expected %h", i, mon_out[i], exp_out[i]); end
    end
    total++;
    if (frame_count !== m_fc) begin bad++; $display("FAIL len_short_frames: got %0d expected %0d", frame_count, m_fc); end
  endtask

  task automatic test_len_overrun();
    start_test();
    push_frame(1'b0, N + 2, 1'b1);
    model_run(); m_fc += 16'(exp_frames);
    wait_quiet("len_over");
    total++;
    if (errlen_cnt != exp_errlen) begin bad++; $display("FAIL len_over_err: got %0d expected %0d", errlen_cnt, exp_errlen); end
    total++;
    if (mon_out.size() != exp_out.size()) begin bad++; $display("FAIL len_over_out_count: got %0d expected %0d", mon_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < mon_out.size(); i++) begin
      total++;
      if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL len_over_out[%0d]: got %h expected %h", i, mon_out[i], exp_out[i]); end
    end
    total++;
    if (frame_count !== m_fc) begin bad++; $display("FAIL len_over_frames: got %0d expected %0d", frame_count, m_fc); end
  endtask

  task automatic test_timeout();
    int lasts;
    start_test();
    echo_limit = 5;
    push_frame(1'b0, N, 1'b1);
    model_run();
    wait_quiet("timeout");
    echo_limit = N;
    total++;
    if (errto_cnt != 1) begin bad++; $display("FAIL timeout_pulse: got %0d expected 1", errto_cnt); end
    total++;
    if (to_cyc - drain_cyc != T) begin bad++; $display("FAIL timeout_delay: got %0d expected %0d", to_cyc - drain_cyc, T); end
    total++;
    if (mon_out.size() != 5) begin bad++; $display("FAIL timeout_out_count: got %0d expected 5", mon_out.size()); end
    lasts = 0;
    for (int i = 0; i < mon_out.size(); i++) begin
      if (mon_out[i].last) lasts++;
      if (i < 5) begin
        total++;
        if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL timeout_out[%0d]: got %h expected %h", i, mon_out[i], exp_out[i]); end
      end
    end
    total++;
    if (lasts != 0) begin bad++; $display("FAIL timeout_last: got %0d expected 0", lasts); end
    total++;
    if (frame_count !== m_fc) begin bad++; $display("FAIL timeout_frames: got %0d expected %0d", frame_count, m_fc); end
  endtask

  task automatic test_bs_inject();
    start_test();
    inject_en = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (mon_out.size() != 0) begin bad++; $display("FAIL inject_idle: got %0d outputs expected 0", mon_out.size()); end
    push_frame(1'b0, N, 1'b1);
    model_run(); m_fc += 16'(exp_frames);
    wait_quiet("inject");
    inject_en = 1'b0;
    total++;
    if (mon_out.size() != exp_out.size()) begin bad++; $display("FAIL inject_out_count: got %0d expected %0d", mon_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < mon_out.size(); i++) begin
      total++;
      if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL inject_out[%0d]: got %h expected %h", i, mon_out[i], exp_out[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      start_test();
      for (int lane = 0; lane < 2; lane++)
        for (int f = 0; f < int'($urandom_range(2, 1)); f++)
          push_frame(lane[0], int'($urandom_range(N, 2)), 1'b1);
      model_run(); m_fc += 16'(exp_frames);
      wait_quiet("random");
      total++;
      if (errlen_cnt != exp_errlen) begin bad++; $display("FAIL random%0d_err: got %0d expected %0d", it, errlen_cnt, exp_errlen); end
      total++;
      if (mon_out.size() != exp_out.size()) begin bad++; $display("FAIL random%0d_out_count: got %0d expected %0d", it, mon_out.size(), exp_out.size()); end
      for (int i = 0; i < exp_out.size() && i < mon_out.size(); i++) begin
        total++;
        if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL random%0d_out[%0d]: got %h expected %h", it, i, mon_out[i], exp_out[i]); end
      end
      total++;
      if (frame_count !== m_fc) begin bad++; $display("FAIL random%0d_frames: got %0d expected %0d", it, frame_count, m_fc); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    start_test();
    push_frame(1'b0, N, 1'b1);
    while (mon_bs.size() < 4 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (mon_bs.size() < 4) begin bad++; $display("FAIL midreset_load: got %0d words expected 4", mon_bs.size()); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL midreset_outputs: got %h expected 0", all_out); end
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_lg = 1'b1; m_fc = '0;
    start_test();
    push_frame(1'b0, N, 1'b1);
    model_run(); m_fc += 16'(exp_frames);
    wait_quiet("midreset");
    total++;
    if (mon_out.size() != exp_out.size()) begin bad++; $display("FAIL midreset_out_count: got %0d expected %0d", mon_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < mon_out.size(); i++) begin
      total++;
      if (mon_out[i] !== exp_out[i]) begin bad++; $display("FAIL midreset_out[%0d]: got %h expected %h", i, mon_out[i], exp_out[i]); end
    end
    total++;
    if (frame_count !== 16'd1) begin bad++; $display("FAIL midreset_frames: got %0d expected 1", frame_count); end
    total++;
    if (errlen_cnt != 0 || errto_cnt != 0) begin bad++; $display("FAIL midreset_err: got len=%0d to=%0d expected 0 0", errlen_cnt, errto_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_len_error();
    test_len_overrun();
    test_timeout();
    test_bs_inject();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_diagonal_backsub_sched.md
Name: dual_diagonal_backsub_sched

Overview:
- Frame scheduler that shares one dual_diagonal_backsub datapath between two requesters (encoder lanes 0 and 1).
- Arbitrates round-robin at frame boundaries and clears the datapath before each frame.
- Streams exactly NUM_WORDS input words into the datapath, then collects NUM_WORDS result words and returns them tagged with the owning requester.
- Only one frame is in flight at a time; length errors and datapath timeouts are flagged.

Parameters:
- WIDTH, 16: data word width (matches datapath).
- NUM_WORDS, 8: words per frame, in and out; must be >= 2.
- TIMEOUT, 64: maximum cycles allowed in DRAIN before abort; must be >= NUM_WORDS.

Ports:
- i_clock  in  1  single clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_req0_data  in  WIDTH  requester 0 word.
- i_req0_valid  in  1  requester 0 word valid.
- i_req0_last  in  1  requester 0 final word of frame.
- o_req0_ready  out  1  requester 0 word accepted when valid & ready.
- i_req1_data, i_req1_valid, i_req1_last, o_req1_ready: same as requester 0, for requester 1.
- o_bs_clear  out  1  one-cycle synchronous clear to datapath.
- o_bs_data  out  WIDTH  word to datapath.
- o_bs_valid  out  1  datapath input valid.
- i_bs_data  in  WIDTH  datapath result word.
- i_bs_valid  in  1  datapath result valid (no backpressure).
- o_out_data  out  WIDTH  result word.
- o_out_valid  out  1  result valid.
- o_out_last  out  1  last result word of frame.
- o_out_src  out  1  owning requester of current result.
- o_busy  out  1  state != IDLE.
- o_err_len  out  1  one-cycle pulse: frame length mismatch.
- o_err_timeout  out  1  one-cycle pulse: drain timeout.
- o_frame_count  out  16  completed frames, wraps at 2^16.

Behaviour:
- Reset (i_reset=0, async): state IDLE; every output 0; last_grant=1, so requester 0 wins the first tie. All counters 0.
- States: IDLE -> CLEAR -> LOAD -> DRAIN -> IDLE.
- IDLE arbitration:
  - No valid requester: stay in IDLE.
  - One valid requester: grant it.
  - Both valid: grant !last_grant.
  - Register grant and last_grant, then go to CLEAR.
- CLEAR: exactly one cycle. o_bs_clear=1. Input and output word counters zeroed. Next state LOAD.
- LOAD:
  - o_reqG_ready=1 for the granted requester only, decoded from registered state (no combinational path from valid). The other ready stays 0.
  - Each accepted beat appears on o_bs_data/o_bs_valid on the next cycle (1-cycle latency); the input counter increments.
  - Accepting beat NUM_WORDS moves to DRAIN; ready is 0 from the following cycle.
  - last asserted on beat k < NUM_WORDS: pulse o_err_len, forward that beat, return to IDLE. No output is produced for that frame; the next frame's CLEAR flushes the datapath.
  - Beat NUM_WORDS without last: pulse o_err_len and proceed to DRAIN normally. Trailing words are treated as the start of a later frame.
- DRAIN:
  - Each i_bs_valid beat is registered to o_out_data/o_out_valid (1-cycle latency) with o_out_src=grant; the output counter increments.
  - On result word NUM_WORDS: o_out_last=1 alongside it, o_frame_count increments, state returns to IDLE.
  - The timeout counter runs every DRAIN cycle. On reaching TIMEOUT before NUM_WORDS results: pulse o_err_timeout, go to IDLE; partial output is not terminated with last.
- i_bs_valid outside DRAIN is ignored and produces no output.
- Back-to-back frames: IDLE is always occupied for at least one cycle between frames, so the minimum frame period is NUM_WORDS + results latency + 3 cycles.
- Widths: word counters $clog2(NUM_WORDS+1) bits; timeout counter $clog2(TIMEOUT+1) bits. No data arithmetic; data passes unmodified.
- Reset mid-frame: immediate return to IDLE and all outputs 0. The in-flight frame is lost; no error pulse.
- Simultaneous DRAIN completion and new request valid: the request is granted in the following IDLE cycle.

Test Plan:
- Single frame, requester 0 sends 0..7 with last on 7; datapath model echoes after 3 cycles -> one o_bs_clear pulse, o_bs_data 0..7, o_out 0..7 with src=0, last on 7, o_frame_count=1.
- Both requesters valid continuously, two frames each -> grant order 0,1,0,1; o_out_src alternates per frame; requester 1 ready stays 0 during requester 0 frames.
- Requester 1 asserts last on word 3 -> o_err_len pulses once, no o_out_valid, state IDLE; next full frame completes correctly.
- Datapath model returns only 5 words -> o_err_timeout pulses exactly TIMEOUT=64 cycles after DRAIN entry, no o_out_last, o_frame_count unchanged.
- Assert i_reset=0 mid-LOAD at word 4 -> all outputs 0 asynchronously; after release a new frame from requester 0 completes with o_frame_count=1.
- Inject i_bs_valid during IDLE and LOAD -> no o_out_valid.
